// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings: transfer types, the word transfer size and response codes.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic       HRESP_OKAY  = 1'b0;
  localparam logic       HRESP_ERROR = 1'b1;

endpackage

// File: rtl/resp_mem_array.sv
// Local word storage for the AHB responder: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module resp_mem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ahb_data_responder.sv
// AHB-Lite word-wide memory subordinate with two-cycle ERROR responses and read-after-write
// forwarding. Define AHB_WAIT_STATES_EN to insert WAIT_CYCLES wait states per legal transfer.
module ahb_data_responder
  import ahb_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR1 = 2'd2,
    ERR2 = 2'd3
`ifdef AHB_WAIT_STATES_EN
    , WAIT = 2'd1
`endif
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  state_t      w_legal_next;
  logic        r_dp_valid;
  logic        r_dp_write;
  logic [AW-1:0] r_idx;
  logic        r_fwd_valid;
  logic [31:0] r_fwd_data;

  logic        w_active;
  logic        w_accept;
  logic        w_addr_err;
  logic        w_complete;
  logic        w_we;
  logic [AW-1:0] w_addr_idx;
  logic [31:0] w_mem_rdata;
  logic        w_readyout;
  logic        w_resp;

`ifdef AHB_WAIT_STATES_EN
  logic [2:0]  r_wait_cnt;
  assign w_legal_next = WAIT;
`else
  assign w_legal_next = IDLE;
`endif

  assign w_active   = (htrans_t'(HTRANS) == HTRANS_NONSEQ) || (htrans_t'(HTRANS) == HTRANS_SEQ);
  assign w_accept   = HSEL && HREADY && w_active && ((r_state == IDLE) || (r_state == ERR2));
  assign w_addr_err = (HADDR[1:0] != 2'b00) || (HSIZE != HSIZE_WORD) || ((HADDR >> 2) >= 32'(DEPTH));
  assign w_addr_idx = HADDR[AW+1:2];
  // A legal data phase completes in IDLE; WAIT holds it off until the counter expires.
  assign w_complete = (r_state == IDLE) && r_dp_valid;
  assign w_we       = w_complete && r_dp_write && !rst;

  resp_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (HWDATA),
    .i_raddr (r_idx),
    .o_rdata (w_mem_rdata)
  );

  always_comb begin
    w_state_next = r_state;
    w_readyout   = 1'b1;
    w_resp       = HRESP_OKAY;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = w_addr_err ? ERR1 : w_legal_next;
        end
      end
`ifdef AHB_WAIT_STATES_EN
      WAIT: begin
        w_readyout = 1'b0;
        if (r_wait_cnt == 3'(WAIT_CYCLES - 1)) begin
          w_state_next = IDLE;
        end
      end
`endif
      ERR1: begin
        w_readyout   = 1'b0;
        w_resp       = HRESP_ERROR;
        w_state_next = ERR2;
      end
      ERR2: begin
        w_resp = HRESP_ERROR;
        if (w_accept) begin
          w_state_next = w_addr_err ? ERR1 : w_legal_next;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_dp_valid  <= 1'b0;
      r_dp_write  <= 1'b0;
      r_idx       <= '0;
      r_fwd_valid <= 1'b0;
      r_fwd_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_dp_valid  <= !w_addr_err;
        r_dp_write  <= HWRITE;
        r_idx       <= w_addr_idx;
        // Read of the word being written right now: keep the fresh HWDATA.
        r_fwd_valid <= !HWRITE && w_we && (w_addr_idx == r_idx);
        r_fwd_data  <= HWDATA;
      end else if (w_complete) begin
        r_dp_valid  <= 1'b0;
        r_fwd_valid <= 1'b0;
      end
    end
  end

`ifdef AHB_WAIT_STATES_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_wait_cnt <= r_wait_cnt + 3'd1;
    end else begin
      r_wait_cnt <= '0;
    end
  end
`endif

  assign HREADYOUT = rst ? 1'b1 : w_readyout;
  assign HRESP     = rst ? HRESP_OKAY : w_resp;
  assign HRDATA    = (!rst && w_complete && !r_dp_write) ?
                     (r_fwd_valid ? r_fwd_data : w_mem_rdata) : 32'h0;

endmodule

// File: tb/tb_ahb_data_responder.sv
// Directed self-checking bench for ahb_data_responder (zero-wait build by default,
// wait-state scenarios when AHB_WAIT_STATES_EN is defined).
module tb_ahb_data_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        hready_mask;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Single-subordinate bus: HREADY follows HREADYOUT unless the bench masks it.
  assign HREADY = HREADYOUT & hready_mask;

  ahb_data_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HREADY    (HREADY),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [31:0] addr, input logic [2:0] size);
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = wr;
    HADDR  = addr;
    HSIZE  = size;
  endtask

  task automatic bus_idle();
    drive(1'b0, 2'b00, 1'b0, 32'h0, 3'b010);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    drive(1'b1, 2'b10, 1'b1, addr, 3'b010);
    step();
    bus_idle();
    HWDATA = data;
    for (int i = 0; i < 20 && HREADYOUT !== 1'b1; i++) step();
    if (HREADYOUT !== 1'b1) begin
      n_err++;
      $display("FAIL write_timeout addr=%h got HREADYOUT=%b want 1", addr, HREADYOUT);
    end
    step();
    $display("write addr=%h data=%h", addr, data);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
    drive(1'b1, 2'b10, 1'b0, addr, 3'b010);
    step();
    bus_idle();
    for (int i = 0; i < 20 && HREADYOUT !== 1'b1; i++) step();
    if (HREADYOUT !== 1'b1) begin
      n_err++;
      $display("FAIL read_timeout addr=%h got HREADYOUT=%b want 1", addr, HREADYOUT);
    end
    data = HRDATA;
    step();
    $display("read  addr=%h data=%h", addr, data);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2'b10, 1'b1, 32'h10, 3'b010);
    HWDATA = 32'hA5A5A5A5;
    step();
    step();
    n_cmp++; if (HREADYOUT !== 1'b1) begin n_err++; $display("FAIL reset_hreadyout got %b want 1", HREADYOUT); end
    n_cmp++; if (HRESP !== 1'b0) begin n_err++; $display("FAIL reset_hresp got %b want 0", HRESP); end
    n_cmp++; if (HRDATA !== 32'h0) begin n_err++; $display("FAIL reset_hrdata got %h want 0", HRDATA); end
    rst = 1'b0;
    bus_idle();
    step();
  endtask

  task automatic test_write_read();
    drive(1'b1, 2'b10, 1'b1, 32'h10, 3'b010);
    step();
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_err++; $display("FAIL wr_resp got %b want 10", {HREADYOUT, HRESP}); end
    HWDATA = 32'hDEADBEEF;
    bus_idle();
    step();
    drive(1'b1, 2'b10, 1'b0, 32'h10, 3'b010);
    step();
    n_cmp++; if (HRDATA !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data got %h want deadbeef", HRDATA); end
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_err++; $display("FAIL rd_resp got %b want 10", {HREADYOUT, HRESP}); end
    bus_idle();
    step();
    $display("write/read 0x10 done");
  endtask

  task automatic test_forwarding();
    drive(1'b1, 2'b10, 1'b1, 32'h20, 3'b010);
    step();
    HWDATA = 32'h11111111;
    drive(1'b1, 2'b10, 1'b0, 32'h20, 3'b010);
    step();
    n_cmp++; if (HRDATA !== 32'h11111111) begin n_err++; $display("FAIL fwd_data got %h want 11111111", HRDATA); end
    n_cmp++; if (HREADYOUT !== 1'b1) begin n_err++; $display("FAIL fwd_ready got %b want 1", HREADYOUT); end
    bus_idle();
    step();
    $display("forwarded read 0x20 done");
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b10, 1'b1, 32'h24, 3'b010);
    step();
    n_cmp++; if (HREADYOUT !== 1'b1) begin n_err++; $display("FAIL b2b_w1_ready got %b want 1", HREADYOUT); end
    HWDATA = 32'hAAAA0024;
    drive(1'b1, 2'b11, 1'b1, 32'h28, 3'b010);
    step();
    n_cmp++; if (HREADYOUT !== 1'b1) begin n_err++; $display("FAIL b2b_w2_ready got %b want 1", HREADYOUT); end
    HWDATA = 32'hBBBB0028;
    drive(1'b1, 2'b10, 1'b0, 32'h24, 3'b010);
    step();
    n_cmp++; if (HRDATA !== 32'hAAAA0024) begin n_err++; $display("FAIL b2b_r1_data got %h want aaaa0024", HRDATA); end
    drive(1'b1, 2'b11, 1'b0, 32'h28, 3'b010);
    step();
    n_cmp++; if (HRDATA !== 32'hBBBB0028) begin n_err++; $display("FAIL b2b_r2_data got %h want bbbb0028", HRDATA); end
    bus_idle();
    step();
    $display("back-to-back 0x24/0x28 done");
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    drive(1'b1, 2'b10, 1'b0, 32'h102, 3'b010);
    step();
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b01) begin n_err++; $display("FAIL mis_err1 got %b want 01", {HREADYOUT, HRESP}); end
    n_cmp++; if (HRDATA !== 32'h0) begin n_err++; $display("FAIL mis_err1_data got %h want 0", HRDATA); end
    bus_idle();
    step();
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b11) begin n_err++; $display("FAIL mis_err2 got %b want 11", {HREADYOUT, HRESP}); end
    step();
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_err++; $display("FAIL mis_after got %b want 10", {HREADYOUT, HRESP}); end
    drive(1'b1, 2'b10, 1'b0, 32'h100, 3'b010);
    step();
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b01) begin n_err++; $display("FAIL oor_err1 got %b want 01", {HREADYOUT, HRESP}); end
    bus_idle();
    step();
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b11) begin n_err++; $display("FAIL oor_err2 got %b want 11", {HREADYOUT, HRESP}); end
    drive(1'b1, 2'b10, 1'b0, 32'h10, 3'b010);
    step();
    n_cmp++; if (HRDATA !== 32'hDEADBEEF) begin n_err++; $display("FAIL err2_pipe_data got %h want deadbeef", HRDATA); end
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_err++; $display("FAIL err2_pipe_resp got %b want 10", {HREADYOUT, HRESP}); end
    drive(1'b1, 2'b10, 1'b1, 32'h12, 3'b010);
    step();
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b01) begin n_err++; $display("FAIL miswr_err1 got %b want 01", {HREADYOUT, HRESP}); end
    HWDATA = 32'hBAD0BAD0;
    bus_idle();
    step();
    step();
    do_read(32'h10, rd);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL miswr_mem got %h want deadbeef", rd); end
  endtask

  task automatic test_size_err();
    logic [31:0] rd;
    do_write(32'h08, 32'h08080808);
    drive(1'b1, 2'b10, 1'b1, 32'h08, 3'b000);
    step();
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b01) begin n_err++; $display("FAIL size_err1 got %b want 01", {HREADYOUT, HRESP}); end
    HWDATA = 32'hFFFFFFFF;
    bus_idle();
    step();
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b11) begin n_err++; $display("FAIL size_err2 got %b want 11", {HREADYOUT, HRESP}); end
    step();
    do_read(32'h08, rd);
    n_cmp++; if (rd !== 32'h08080808) begin n_err++; $display("FAIL size_mem got %h want 08080808", rd); end
  endtask

  task automatic test_idle_busy();
    logic [31:0] rd;
    drive(1'b1, 2'b01, 1'b1, 32'h10, 3'b010);
    step();
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_err++; $display("FAIL busy_resp got %b want 10", {HREADYOUT, HRESP}); end
    HWDATA = 32'h55555555;
    drive(1'b0, 2'b10, 1'b1, 32'h10, 3'b010);
    step();
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_err++; $display("FAIL nosel_resp got %b want 10", {HREADYOUT, HRESP}); end
    HWDATA = 32'h66666666;
    bus_idle();
    step();
    do_read(32'h10, rd);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL busy_mem got %h want deadbeef", rd); end
  endtask

  task automatic test_hready_low();
    logic [31:0] rd;
    do_write(32'h30, 32'h30303030);
    hready_mask = 1'b0;
    drive(1'b1, 2'b10, 1'b1, 32'h30, 3'b010);
    step();
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_err++; $display("FAIL hrdy_low_resp got %b want 10", {HREADYOUT, HRESP}); end
    hready_mask = 1'b1;
    HWDATA = 32'h77777777;
    bus_idle();
    step();
    do_read(32'h30, rd);
    n_cmp++; if (rd !== 32'h30303030) begin n_err++; $display("FAIL hrdy_low_mem got %h want 30303030", rd); end
  endtask

  task automatic test_reset_midwrite();
    logic [31:0] rd;
    do_write(32'h0C, 32'h0C0C0C0C);
    drive(1'b1, 2'b10, 1'b1, 32'h0C, 3'b010);
    step();
`ifdef AHB_WAIT_STATES_EN
    n_cmp++; if (HREADYOUT !== 1'b0) begin n_err++; $display("FAIL rstw_in_wait got %b want 0", HREADYOUT); end
`endif
    HWDATA = 32'h99999999;
    bus_idle();
    rst = 1'b1;
    #1;
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_err++; $display("FAIL rstw_resp got %b want 10", {HREADYOUT, HRESP}); end
    n_cmp++; if (HRDATA !== 32'h0) begin n_err++; $display("FAIL rstw_data got %h want 0", HRDATA); end
    step();
    rst = 1'b0;
    step();
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_err++; $display("FAIL rstw_after got %b want 10", {HREADYOUT, HRESP}); end
    do_read(32'h0C, rd);
    n_cmp++; if (rd !== 32'h0C0C0C0C) begin n_err++; $display("FAIL rstw_mem got %h want 0c0c0c0c", rd); end
  endtask

`ifdef AHB_WAIT_STATES_EN
  task automatic test_wait_states();
    drive(1'b1, 2'b10, 1'b1, 32'h04, 3'b010);
    step();
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b00) begin n_err++; $display("FAIL wsw_w1 got %b want 00", {HREADYOUT, HRESP}); end
    HWDATA = 32'h04040404;
    bus_idle();
    step();
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b00) begin n_err++; $display("FAIL wsw_w2 got %b want 00", {HREADYOUT, HRESP}); end
    step();
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_err++; $display("FAIL wsw_done got %b want 10", {HREADYOUT, HRESP}); end
    drive(1'b1, 2'b10, 1'b0, 32'h04, 3'b010);
    step();
    bus_idle();
    n_cmp++; if (HREADYOUT !== 1'b0) begin n_err++; $display("FAIL wsr_w1 got %b want 0", HREADYOUT); end
    step();
    n_cmp++; if (HREADYOUT !== 1'b0) begin n_err++; $display("FAIL wsr_w2 got %b want 0", HREADYOUT); end
    step();
    n_cmp++; if (HREADYOUT !== 1'b1) begin n_err++; $display("FAIL wsr_done got %b want 1", HREADYOUT); end
    n_cmp++; if (HRDATA !== 32'h04040404) begin n_err++; $display("FAIL wsr_data got %h want 04040404", HRDATA); end
    step();
    $display("wait-state write/read 0x04 done");
  endtask
`endif

  initial begin
    hready_mask = 1'b1;
    HWDATA = 32'h0;
    bus_idle();
    test_reset();
`ifdef AHB_WAIT_STATES_EN
    test_wait_states();
`else
    test_write_read();
    test_forwarding();
    test_back_to_back();
    test_errors();
    test_size_err();
    test_idle_busy();
`endif
    test_hready_low();
    test_reset_midwrite();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
